// File: rtl/sim_console_arbiter.sv
// sim_console_arbiter: shares the simulation console byte stream among
// NUM_REQ producers. Each producer fills a private line buffer; a round-robin
// scheduler drains one complete line at a time so lines never interleave.
// Optional build macro CONSOLE_ARB_PREFIX_EN: each drained line is preceded
// by the tag "[n] " where n is the requester index.
module sim_console_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LINE_DEPTH   = 64,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_ch,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_ch,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CW = $clog2(LINE_DEPTH + 1);
  localparam int AW = $clog2(LINE_DEPTH);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(LINE_DEPTH);

`ifdef CONSOLE_ARB_PREFIX_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_PREFIX} state_t;
`else
  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;
`endif

  // Line storage and per-buffer bookkeeping
  logic [7:0]    line_mem [NUM_REQ][LINE_DEPTH];
  logic [CW-1:0] cnt_reg  [NUM_REQ];
  logic [IW-1:0] idle_reg [NUM_REQ];
  logic [NUM_REQ-1:0] done_reg;

  // Scheduler state
  state_t        state_reg;
  logic [SW-1:0] sel_reg;
  logic [SW-1:0] last_reg;
  logic [AW-1:0] rd_reg;
  logic          out_valid_reg;
  logic [7:0]    out_ch_reg;
`ifdef CONSOLE_ARB_PREFIX_EN
  logic [1:0]    pfx_reg;
`endif

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] push_done;
  logic [NUM_REQ-1:0] timeout;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] clear;
  logic [7:0]         req_byte [NUM_REQ];
  logic [CW-1:0]      cnt_sel;
  logic               drain_last;
  logic               grant_found;
  logic [SW-1:0]      grant_idx;

  assign cnt_sel    = cnt_reg[sel_reg];
  assign drain_last = (state_reg == ST_DRAIN) && out_ready &&
                      ({1'b0, rd_reg} == (cnt_sel - CW'(1)));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_byte[gi]  = req_ch[8*gi +: 8];
      assign req_ready[gi] = !reset && !done_reg[gi];
      assign push[gi]      = req_valid[gi] && req_ready[gi];
      assign nonempty[gi]  = (cnt_reg[gi] != '0);
      // A line completes on newline or when the buffer fills up
      assign push_done[gi] = push[gi] &&
                             ((req_byte[gi] == 8'h0A) || ((cnt_reg[gi] + CW'(1)) == CNT_FULL));
      // A stalled partial line is force-completed after the idle window
      assign timeout[gi]   = (FLUSH_CYCLES != 0) && !push[gi] && !done_reg[gi] &&
                             nonempty[gi] && (idle_reg[gi] == IDLE_LAST);
      // The buffer being drained is released when its last byte is taken
      assign clear[gi]     = drain_last && (sel_reg == SW'(gi));
    end
  endgenerate

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && done_reg[(int'(last_reg) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = SW'((int'(last_reg) + k) % NUM_REQ);
      end
    end
  end

  // Byte writes into the line buffers (no reset on storage)
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        line_mem[i][cnt_reg[i][AW-1:0]] <= req_byte[i];
      end
    end
  end

  // Per-buffer fill count, line-complete flag and idle timer
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_reg[i]  <= '0;
        idle_reg[i] <= '0;
      end
      done_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (clear[i]) begin
          cnt_reg[i]  <= '0;
          done_reg[i] <= 1'b0;
          idle_reg[i] <= '0;
        end else if (push[i]) begin
          cnt_reg[i]  <= cnt_reg[i] + CW'(1);
          idle_reg[i] <= '0;
          if (push_done[i]) begin
            done_reg[i] <= 1'b1;
          end
        end else if (timeout[i]) begin
          done_reg[i] <= 1'b1;
          idle_reg[i] <= '0;
        end else if (nonempty[i] && !done_reg[i]) begin
          idle_reg[i] <= idle_reg[i] + IW'(1);
        end else begin
          idle_reg[i] <= '0;
        end
      end
    end
  end

  // Grant / drain state machine with registered console outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      last_reg      <= SW'(NUM_REQ - 1);
      rd_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_ch_reg    <= 8'h00;
`ifdef CONSOLE_ARB_PREFIX_EN
      pfx_reg       <= 2'd0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_found) begin
            sel_reg       <= grant_idx;
            last_reg      <= grant_idx;
            rd_reg        <= '0;
            out_valid_reg <= 1'b1;
`ifdef CONSOLE_ARB_PREFIX_EN
            state_reg     <= ST_PREFIX;
            pfx_reg       <= 2'd0;
            out_ch_reg    <= 8'h5B;
`else
            state_reg     <= ST_DRAIN;
            out_ch_reg    <= line_mem[grant_idx][{AW{1'b0}}];
`endif
          end
        end
`ifdef CONSOLE_ARB_PREFIX_EN
        ST_PREFIX: begin
          if (out_ready) begin
            pfx_reg <= pfx_reg + 2'd1;
            case (pfx_reg)
              2'd0:    out_ch_reg <= 8'h30 + 8'(sel_reg);
              2'd1:    out_ch_reg <= 8'h5D;
              2'd2:    out_ch_reg <= 8'h20;
              default: begin
                out_ch_reg <= line_mem[sel_reg][{AW{1'b0}}];
                state_reg  <= ST_DRAIN;
              end
            endcase
          end
        end
`endif
        ST_DRAIN: begin
          if (out_ready) begin
            if (drain_last) begin
              state_reg     <= ST_IDLE;
              out_valid_reg <= 1'b0;
              out_ch_reg    <= 8'h00;
            end else begin
              rd_reg     <= rd_reg + AW'(1);
              out_ch_reg <= line_mem[sel_reg][rd_reg + AW'(1)];
            end
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_ch    = out_ch_reg;
  assign busy      = (state_reg != ST_IDLE) || (|nonempty);

endmodule

// File: tb/tb_sim_console_arbiter.sv
// Directed bench for sim_console_arbiter: a per-cycle vector table for the
// basic line and back-pressure cases, then hand-written sequences for
// round-robin, full buffer, idle flush and reset mid-drain.
module tb_sim_console_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_ch = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_ch;
  logic        out_ready = 1'b1;
  logic        busy;

  always #5 clock = ~clock;

  sim_console_arbiter #(
    .NUM_REQ(4), .LINE_DEPTH(64), .FLUSH_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .out_valid(out_valid), .out_ch(out_ch), .out_ready(out_ready),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink-side capture of every accepted console byte and its cycle
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         cyc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && out_valid && out_ready) begin
      got_q.push_back(out_ch);
      got_cyc.push_back(cyc);
      $display("out byte %02h at cycle %0d", out_ch, cyc);
    end
  end

  function automatic logic [31:0] lane(input int idx, input logic [7:0] b);
    return 32'(b) << (8 * idx);
  endfunction

  function automatic logic [8:0] q_at(input int i);
    return (i < got_q.size()) ? {1'b0, got_q[i]} : 9'h1FF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -1000;
  endfunction

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] ch;
    logic        ordy;
    logic        e_valid;
    logic        chk_ch;
    logic [7:0]  e_ch;
    logic        e_busy;
    logic [3:0]  e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [31:0] ch,
                              input logic ordy, input logic e_valid, input logic chk_ch,
                              input logic [7:0] e_ch, input logic e_busy, input logic [3:0] e_ready);
    vec_t v;
    v.rst = rst; v.valid = valid; v.ch = ch; v.ordy = ordy; v.e_valid = e_valid;
    v.chk_ch = chk_ch; v.e_ch = e_ch; v.e_busy = e_busy; v.e_ready = e_ready;
    return v;
  endfunction

  task automatic push(input int idx, input logic [7:0] b);
    req_valid = 4'(1 << idx);
    req_ch    = lane(idx, b);
    @(posedge clock); #1;
    req_valid = '0;
    req_ch    = '0;
  endtask

  task automatic wait_bytes(input string name, input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin
      @(posedge clock); #1;
      t++;
    end
    check(name, got_q.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_a [6];
    int bad;
    int t;

    // rst valid ch ordy | e_valid chk_ch e_ch e_busy e_ready
    vecs.push_back(mk(1, 4'b0000, 32'h0,         1, 0, 1, 8'h00, 0, 4'b0000)); // reset state
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 0, 0, 8'h00, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0001, lane(0,8'h68), 1, 0, 0, 8'h00, 1, 4'b1111)); // 'h'
    vecs.push_back(mk(0, 4'b0001, lane(0,8'h69), 1, 0, 0, 8'h00, 1, 4'b1111)); // 'i'
    vecs.push_back(mk(0, 4'b0001, lane(0,8'h0A), 1, 0, 0, 8'h00, 1, 4'b1110)); // newline -> done
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h68, 1, 4'b1110)); // grant
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h69, 1, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h0A, 1, 4'b1110));
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 0, 0, 8'h00, 0, 4'b1111)); // drained
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 0, 0, 8'h00, 0, 4'b1111));
    vecs.push_back(mk(0, 4'b0010, lane(1,8'h41), 1, 0, 0, 8'h00, 1, 4'b1111)); // req1 "ABC\n"
    vecs.push_back(mk(0, 4'b0010, lane(1,8'h42), 1, 0, 0, 8'h00, 1, 4'b1111));
    vecs.push_back(mk(0, 4'b0010, lane(1,8'h43), 1, 0, 0, 8'h00, 1, 4'b1111));
    vecs.push_back(mk(0, 4'b0010, lane(1,8'h0A), 1, 0, 0, 8'h00, 1, 4'b1101));
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h41, 1, 4'b1101)); // grant req1
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h42, 1, 4'b1101)); // 'A' taken
    for (int i = 0; i < 5; i++)                                                 // sink stalls
      vecs.push_back(mk(0, 4'b0000, 32'h0,       0, 1, 1, 8'h42, 1, 4'b1101));
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h43, 1, 4'b1101));
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 1, 1, 8'h0A, 1, 4'b1101));
    vecs.push_back(mk(0, 4'b0000, 32'h0,         1, 0, 0, 8'h00, 0, 4'b1111));

    for (int i = 0; i < vecs.size(); i++) begin
      reset     = vecs[i].rst;
      req_valid = vecs[i].valid;
      req_ch    = vecs[i].ch;
      out_ready = vecs[i].ordy;
      @(posedge clock); #1;
      $display("vec %0d: out_valid=%0b out_ch=%02h busy=%0b req_ready=%04b",
               i, out_valid, out_ch, busy, req_ready);
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].chk_ch) check($sformatf("v%0d_out_ch", i), 32'(out_ch), 32'(vecs[i].e_ch));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
    end
    req_valid = '0;
    req_ch    = '0;
    out_ready = 1'b1;

    // Round-robin: req0 and req2 complete together, then req0 again
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
    got_q.delete(); got_cyc.delete();
    req_valid = 4'b0101; req_ch = lane(0, 8'h70) | lane(2, 8'h71);
    @(posedge clock); #1;
    req_ch = lane(0, 8'h0A) | lane(2, 8'h0A);
    @(posedge clock); #1;
    req_valid = '0; req_ch = '0;
    t = 0;
    while (!req_ready[0] && t < 50) begin @(posedge clock); #1; t++; end
    check("rr_req0_ready_return", 32'(req_ready[0]), 32'd1);
    push(0, 8'h72);
    push(0, 8'h0A);
    wait_bytes("rr_byte_count", 6, 100);
    exp_a = '{8'h70, 8'h0A, 8'h71, 8'h0A, 8'h72, 8'h0A};
    for (int i = 0; i < 6; i++) check($sformatf("rr_byte%0d", i), 32'(q_at(i)), 32'(exp_a[i]));
    check("rr_line0_consecutive", 32'(cyc_at(1) - cyc_at(0)), 32'd1);
    check("rr_one_bubble", 32'(cyc_at(2) - cyc_at(1)), 32'd2);

    // Full buffer: 64 bytes with no newline on req1
    got_q.delete(); got_cyc.delete();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!req_ready[1]) bad++;
      push(1, 8'(8'h20 + i));
    end
    check("full_ready_while_filling", 32'(bad), 32'd0);
    check("full_ready_after_64", 32'(req_ready[1]), 32'd0);
    wait_bytes("full_byte_count", 64, 200);
    check("full_ready_after_drain", 32'(req_ready[1]), 32'd1);
    check("full_busy_after_drain", 32'(busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (q_at(i) != 9'(8'h20 + i)) bad++;
    check("full_bytes_mismatched", 32'(bad), 32'd0);

    // Idle flush of a partial line on req3
    got_q.delete(); got_cyc.delete();
    push(3, 8'h61);
    push(3, 8'h62);
    repeat (15) begin @(posedge clock); #1; end
    check("flush_ready_before_window", 32'(req_ready[3]), 32'd1);
    @(posedge clock); #1;
    check("flush_ready_after_window", 32'(req_ready[3]), 32'd0);
    wait_bytes("flush_byte_count", 2, 50);
    check("flush_byte0", 32'(q_at(0)), 32'h61);
    check("flush_byte1", 32'(q_at(1)), 32'h62);

    // Reset in the middle of a drain
    got_q.delete(); got_cyc.delete();
    push(0, 8'h78);
    push(0, 8'h79);
    push(0, 8'h0A);
    t = 0;
    while (!out_valid && t < 10) begin @(posedge clock); #1; t++; end
    check("rst_drain_started", 32'(out_valid), 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    got_q.delete(); got_cyc.delete();
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(req_ready), 32'hF);
    repeat (12) begin @(posedge clock); #1; end
    check("rst_no_stale_bytes", 32'(got_q.size()), 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
